// File: rtl/ram_port_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : ram_port_arbiter
// Purpose  : Serialises two requesters onto one RAM port (round-robin or
//            fixed priority) and returns read data with a one-cycle ack.
// Revision : 1.0 - initial release
// ============================================================================
module ram_port_arbiter #(
    parameter int AW         = 32,
    parameter int DW         = 32,
    parameter int RD_LATENCY = 1,
    parameter int ARB_MODE   = 0
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          req0,
    input  logic          we0,
    input  logic [AW-1:0] addr0,
    input  logic [DW-1:0] wdata0,
    output logic          ack0,
    output logic [DW-1:0] rdata0,
    input  logic          req1,
    input  logic          we1,
    input  logic [AW-1:0] addr1,
    input  logic [DW-1:0] wdata1,
    output logic          ack1,
    output logic [DW-1:0] rdata1,
    input  logic [DW-1:0] ram_read_data,
    output logic [AW-1:0] ram_address,
    output logic [DW-1:0] ram_write_data,
    output logic          ram_read_req,
    output logic          ram_write_req,
    output logic          grant,
    output logic          busy
);

    localparam logic [2:0] c_LATENCY = 3'(RD_LATENCY);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_WAIT  = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    state_t     r_state;
    logic       r_lastGrant;
    logic       r_we;
    logic [2:0] r_waitCnt;

    logic          w_anyReq;
    logic          w_pick;
    logic          w_pickWe;
    logic [AW-1:0] w_pickAddr;
    logic [DW-1:0] w_pickWdata;

    // Port selection for the current IDLE cycle; only used when w_anyReq.
    always_comb begin
        w_anyReq = req0 | req1;
        w_pick   = req1 & ~req0;
        if (req0 && req1) begin
            w_pick = (ARB_MODE == 1) ? 1'b0 : ~r_lastGrant;
        end
        w_pickWe    = w_pick ? we1    : we0;
        w_pickAddr  = w_pick ? addr1  : addr0;
        w_pickWdata = w_pick ? wdata1 : wdata0;
    end

    // Outputs are set on the edge entering the state they belong to, so the
    // strobe lines up with ISSUE and the ack with DONE.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state        <= S_IDLE;
            r_lastGrant    <= 1'b1;
            r_we           <= 1'b0;
            r_waitCnt      <= 3'd0;
            ack0           <= 1'b0;
            ack1           <= 1'b0;
            rdata0         <= '0;
            rdata1         <= '0;
            ram_address    <= '0;
            ram_write_data <= '0;
            ram_read_req   <= 1'b0;
            ram_write_req  <= 1'b0;
            grant          <= 1'b0;
            busy           <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_anyReq) begin
                        grant          <= w_pick;
                        busy           <= 1'b1;
                        r_we           <= w_pickWe;
                        ram_address    <= w_pickAddr;
                        ram_write_data <= w_pickWdata;
                        ram_read_req   <= ~w_pickWe;
                        ram_write_req  <= w_pickWe;
                        r_state        <= S_ISSUE;
                    end
                end
                S_ISSUE: begin
                    ram_read_req  <= 1'b0;
                    ram_write_req <= 1'b0;
                    r_waitCnt     <= c_LATENCY;
                    r_state       <= S_WAIT;
                end
                S_WAIT: begin
                    r_waitCnt <= r_waitCnt - 3'd1;
                    if (r_waitCnt == 3'd1) begin
                        if (!r_we) begin
                            if (grant) begin
                                rdata1 <= ram_read_data;
                            end else begin
                                rdata0 <= ram_read_data;
                            end
                        end
                        ack0    <= ~grant;
                        ack1    <= grant;
                        r_state <= S_DONE;
                    end
                end
                S_DONE: begin
                    ack0        <= 1'b0;
                    ack1        <= 1'b0;
                    busy        <= 1'b0;
                    r_lastGrant <= grant;
                    r_state     <= S_IDLE;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_ram_port_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_ram_port_arbiter
// Purpose  : Directed bench for ram_port_arbiter; instance A uses defaults,
//            instance B uses RD_LATENCY=3 with fixed priority.
// Revision : 1.0 - initial release
// ============================================================================
module tb_ram_port_arbiter;

    logic        clk;
    logic        reset;
    logic        req0, we0, req1, we1;
    logic [31:0] addr0, wdata0, addr1, wdata1;

    logic        ackA0, ackA1, ramRdA, ramWrA, grantA, busyA;
    logic [31:0] rdataA0, rdataA1, ramDataA, ramAddrA, ramWdataA;
    logic        ackB0, ackB1, ramRdB, ramWrB, grantB, busyB;
    logic [31:0] rdataB0, rdataB1, ramDataB, ramAddrB, ramWdataB;

    logic        loadEn;
    logic [7:0]  loadIdx;
    logic [31:0] loadData;

    int checks = 0;
    int errors = 0;

    ram_port_arbiter #(.AW(32), .DW(32), .RD_LATENCY(1), .ARB_MODE(0)) dutA (
        .clk(clk), .reset(reset),
        .req0(req0), .we0(we0), .addr0(addr0), .wdata0(wdata0), .ack0(ackA0), .rdata0(rdataA0),
        .req1(req1), .we1(we1), .addr1(addr1), .wdata1(wdata1), .ack1(ackA1), .rdata1(rdataA1),
        .ram_read_data(ramDataA), .ram_address(ramAddrA), .ram_write_data(ramWdataA),
        .ram_read_req(ramRdA), .ram_write_req(ramWrA), .grant(grantA), .busy(busyA)
    );

    ram_port_arbiter #(.AW(32), .DW(32), .RD_LATENCY(3), .ARB_MODE(1)) dutB (
        .clk(clk), .reset(reset),
        .req0(req0), .we0(we0), .addr0(addr0), .wdata0(wdata0), .ack0(ackB0), .rdata0(rdataB0),
        .req1(req1), .we1(we1), .addr1(addr1), .wdata1(wdata1), .ack1(ackB1), .rdata1(rdataB1),
        .ram_read_data(ramDataB), .ram_address(ramAddrB), .ram_write_data(ramWdataB),
        .ram_read_req(ramRdB), .ram_write_req(ramWrB), .grant(grantB), .busy(busyB)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // RAM models: read data is valid only in the one cycle it should be sampled.
    logic [31:0] memA [0:255];
    logic [31:0] dataA;
    logic        vldA = 1'b0;
    always @(posedge clk) begin
        if (loadEn) memA[loadIdx] <= loadData;
        if (ramWrA) memA[ramAddrA[9:2]] <= ramWdataA;
        vldA  <= ramRdA;
        dataA <= memA[ramAddrA[9:2]];
    end
    assign ramDataA = vldA ? dataA : 32'hBAD0_BAD0;

    logic [31:0] memB  [0:255];
    logic [31:0] pipeB [0:2];
    logic [2:0]  vldB = 3'b000;
    always @(posedge clk) begin
        if (loadEn) memB[loadIdx] <= loadData;
        if (ramWrB) memB[ramAddrB[9:2]] <= ramWdataB;
        vldB     <= {vldB[1:0], ramRdB};
        pipeB[0] <= memB[ramAddrB[9:2]];
        pipeB[1] <= pipeB[0];
        pipeB[2] <= pipeB[1];
    end
    assign ramDataB = vldB[2] ? pipeB[2] : 32'hBAD0_BAD0;

    task automatic apply_reset();
        reset = 1'b1;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
    endtask

    task automatic load_word(input logic [31:0] addr, input logic [31:0] data);
        @(negedge clk);
        loadEn = 1'b1; loadIdx = addr[9:2]; loadData = data;
        @(negedge clk);
        loadEn = 1'b0;
    endtask

    // Raises one request and follows it to its ack (or a cycle budget).
    task automatic do_txn(input bit useB, input bit port, input bit we,
                          input logic [31:0] addr, input logic [31:0] wdata,
                          output int cyc, output int nRd, output int nWr,
                          output int nOther, output int stbCyc,
                          output logic [31:0] stbAddr, output logic [31:0] stbData);
        logic ack, other, rd, wr;
        cyc = 0; nRd = 0; nWr = 0; nOther = 0; stbCyc = 0;
        stbAddr = '0; stbData = '0; ack = 1'b0;
        if (port) begin we1 = we; addr1 = addr; wdata1 = wdata; req1 = 1'b1; end
        else      begin we0 = we; addr0 = addr; wdata0 = wdata; req0 = 1'b1; end
        while (!ack && cyc < 30) begin
            @(negedge clk);
            cyc++;
            rd    = useB ? ramRdB : ramRdA;
            wr    = useB ? ramWrB : ramWrA;
            ack   = useB ? (port ? ackB1 : ackB0) : (port ? ackA1 : ackA0);
            other = useB ? (port ? ackB0 : ackB1) : (port ? ackA0 : ackA1);
            if (rd || wr) begin
                stbCyc  = cyc;
                stbAddr = useB ? ramAddrB : ramAddrA;
                stbData = useB ? ramWdataB : ramWdataA;
            end
            if (rd === 1'b1) nRd++;
            if (wr === 1'b1) nWr++;
            if (other === 1'b1) nOther++;
        end
        if (port) req1 = 1'b0; else req0 = 1'b0;
        if (!ack) cyc = -1;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (2) @(negedge clk);
        checks++; if (busyA !== 1'b0) begin errors++; $display("FAIL reset_busy_held: got %b expected 0", busyA); end
        reset = 1'b0;
        @(negedge clk);
        checks++; if ({ackA0, ackA1, ramRdA, ramWrA, grantA, busyA} !== 6'b0) begin
            errors++; $display("FAIL reset_ctrlA: got %b expected 000000", {ackA0, ackA1, ramRdA, ramWrA, grantA, busyA}); end
        checks++; if (rdataA0 !== 32'h0) begin errors++; $display("FAIL reset_rdata0: got %h expected 0", rdataA0); end
        checks++; if (rdataA1 !== 32'h0) begin errors++; $display("FAIL reset_rdata1: got %h expected 0", rdataA1); end
        checks++; if (ramAddrA !== 32'h0) begin errors++; $display("FAIL reset_addr: got %h expected 0", ramAddrA); end
        checks++; if (ramWdataA !== 32'h0) begin errors++; $display("FAIL reset_wdata: got %h expected 0", ramWdataA); end
        checks++; if ({ackB0, ackB1, ramRdB, ramWrB, grantB, busyB, rdataB0, rdataB1} !== 70'b0) begin
            errors++; $display("FAIL reset_B: got %h expected 0", {ackB0, ackB1, ramRdB, ramWrB, grantB, busyB, rdataB0, rdataB1}); end
    endtask

    task automatic test_single_read();
        int cyc, nRd, nWr, nOther, stbCyc;
        logic [31:0] sA, sD;
        load_word(32'h100, 32'hDEADBEEF);
        do_txn(1'b0, 1'b0, 1'b0, 32'h100, 32'h0, cyc, nRd, nWr, nOther, stbCyc, sA, sD);
        checks++; if (cyc !== 3) begin errors++; $display("FAIL read_ack_latency: got %0d expected 3", cyc); end
        checks++; if (nRd !== 1 || nWr !== 0) begin errors++; $display("FAIL read_strobes: got rd=%0d wr=%0d expected rd=1 wr=0", nRd, nWr); end
        checks++; if (stbCyc !== 1 || sA !== 32'h100) begin errors++; $display("FAIL read_strobe_addr: got cyc=%0d addr=%h expected cyc=1 addr=100", stbCyc, sA); end
        checks++; if (rdataA0 !== 32'hDEADBEEF) begin errors++; $display("FAIL read_rdata0: got %h expected deadbeef", rdataA0); end
        checks++; if (nOther !== 0) begin errors++; $display("FAIL read_ack1: got %0d pulses expected 0", nOther); end
        @(negedge clk);
        checks++; if (ackA0 !== 1'b0 || busyA !== 1'b0) begin errors++; $display("FAIL read_after_done: got ack0=%b busy=%b expected 0 0", ackA0, busyA); end
    endtask

    task automatic test_write_readback();
        int cyc, nRd, nWr, nOther, stbCyc;
        logic [31:0] sA, sD;
        do_txn(1'b0, 1'b1, 1'b1, 32'h20, 32'h12345678, cyc, nRd, nWr, nOther, stbCyc, sA, sD);
        checks++; if (cyc !== 3) begin errors++; $display("FAIL write_ack_latency: got %0d expected 3", cyc); end
        checks++; if (nWr !== 1 || nRd !== 0) begin errors++; $display("FAIL write_strobes: got rd=%0d wr=%0d expected rd=0 wr=1", nRd, nWr); end
        checks++; if (sA !== 32'h20 || sD !== 32'h12345678) begin errors++; $display("FAIL write_bus: got addr=%h data=%h expected 20 12345678", sA, sD); end
        checks++; if (rdataA1 !== 32'h0) begin errors++; $display("FAIL write_rdata1_kept: got %h expected 0", rdataA1); end
        @(negedge clk);
        do_txn(1'b0, 1'b1, 1'b0, 32'h20, 32'h0, cyc, nRd, nWr, nOther, stbCyc, sA, sD);
        checks++; if (cyc !== 3 || nRd !== 1) begin errors++; $display("FAIL readback_timing: got cyc=%0d rd=%0d expected 3 1", cyc, nRd); end
        checks++; if (rdataA1 !== 32'h12345678) begin errors++; $display("FAIL readback_rdata1: got %h expected 12345678", rdataA1); end
        checks++; if (rdataA0 !== 32'hDEADBEEF) begin errors++; $display("FAIL readback_rdata0_kept: got %h expected deadbeef", rdataA0); end
        @(negedge clk);
    endtask

    task automatic test_reset_mid_op();
        int cyc, nRd, nWr, nOther, stbCyc, n;
        logic [31:0] sA, sD;
        we0 = 1'b0; addr0 = 32'h100; req0 = 1'b1;
        @(negedge clk);
        @(negedge clk);
        checks++; if (busyA !== 1'b1 || ramRdA !== 1'b0) begin errors++; $display("FAIL midrst_in_wait: got busy=%b rd=%b expected 1 0", busyA, ramRdA); end
        #2 reset = 1'b1; req0 = 1'b0;
        #1;
        checks++; if ({busyA, ackA0, ramRdA, ramWrA, grantA} !== 5'b0) begin
            errors++; $display("FAIL midrst_ctrl: got %b expected 00000", {busyA, ackA0, ramRdA, ramWrA, grantA}); end
        checks++; if (rdataA0 !== 32'h0 || ramAddrA !== 32'h0) begin errors++; $display("FAIL midrst_data: got rdata0=%h addr=%h expected 0 0", rdataA0, ramAddrA); end
        @(negedge clk);
        reset = 1'b0;
        n = 0;
        repeat (6) begin
            @(negedge clk);
            if (ackA0 !== 1'b0 || ackA1 !== 1'b0 || busyA !== 1'b0) n++;
        end
        checks++; if (n !== 0) begin errors++; $display("FAIL midrst_no_ack: got %0d active cycles expected 0", n); end
        do_txn(1'b0, 1'b0, 1'b0, 32'h100, 32'h0, cyc, nRd, nWr, nOther, stbCyc, sA, sD);
        checks++; if (cyc !== 3 || rdataA0 !== 32'hDEADBEEF) begin errors++; $display("FAIL midrst_reissue: got cyc=%0d rdata0=%h expected 3 deadbeef", cyc, rdataA0); end
        @(negedge clk);
    endtask

    task automatic test_round_robin();
        int nAck, lastCyc, cyc;
        logic [1:0] reraise;
        apply_reset();
        we0 = 1'b0; we1 = 1'b0; addr0 = 32'h100; addr1 = 32'h20;
        req0 = 1'b1; req1 = 1'b1; reraise = 2'b00;
        nAck = 0; lastCyc = 0; cyc = 0;
        while (nAck < 4 && cyc < 40) begin
            @(negedge clk);
            cyc++;
            if (reraise[0]) req0 = 1'b1;
            if (reraise[1]) req1 = 1'b1;
            reraise = 2'b00;
            checks++; if ((ackA0 & ackA1) !== 1'b0 || (ramRdA & ramWrA) !== 1'b0) begin
                errors++; $display("FAIL rr_exclusive: got acks=%b%b strobes=%b%b expected no pair", ackA0, ackA1, ramRdA, ramWrA); end
            if (ackA0 || ackA1) begin
                checks++; if (ackA1 !== nAck[0]) begin errors++; $display("FAIL rr_order: ack %0d got port %b expected %b", nAck, ackA1, nAck[0]); end
                checks++; if (cyc - lastCyc !== ((nAck == 0) ? 3 : 4)) begin
                    errors++; $display("FAIL rr_spacing: ack %0d got %0d cycles expected %0d", nAck, cyc - lastCyc, (nAck == 0) ? 3 : 4); end
                lastCyc = cyc;
                nAck++;
                if (ackA0) begin req0 = 1'b0; reraise[0] = 1'b1; end
                else       begin req1 = 1'b0; reraise[1] = 1'b1; end
            end
        end
        req0 = 1'b0; req1 = 1'b0;
        checks++; if (nAck !== 4) begin errors++; $display("FAIL rr_timeout: got %0d acks expected 4", nAck); end
    endtask

    task automatic test_fixed_priority();
        int n0, cyc, lastCyc;
        bit seen1, reraise;
        apply_reset();
        we0 = 1'b0; we1 = 1'b0; addr0 = 32'h100; addr1 = 32'h20;
        req0 = 1'b1; req1 = 1'b1;
        n0 = 0; cyc = 0; lastCyc = 0; seen1 = 1'b0; reraise = 1'b0;
        while (!seen1 && cyc < 100) begin
            @(negedge clk);
            cyc++;
            if (reraise) begin req0 = 1'b1; reraise = 1'b0; end
            if (ackB1) begin
                seen1 = 1'b1; req1 = 1'b0;
                checks++; if (n0 !== 4) begin errors++; $display("FAIL fp_port1_early: got after %0d port0 acks expected 4", n0); end
                checks++; if (cyc - lastCyc !== 6) begin errors++; $display("FAIL fp_port1_spacing: got %0d expected 6", cyc - lastCyc); end
            end
            if (ackB0) begin
                checks++; if (cyc - lastCyc !== ((n0 == 0) ? 5 : 6)) begin
                    errors++; $display("FAIL fp_spacing: ack %0d got %0d expected %0d", n0, cyc - lastCyc, (n0 == 0) ? 5 : 6); end
                lastCyc = cyc;
                n0++;
                req0 = 1'b0;
                if (n0 < 4) reraise = 1'b1;
            end
        end
        req0 = 1'b0; req1 = 1'b0;
        checks++; if (!seen1) begin errors++; $display("FAIL fp_timeout: got no ack1 expected one after %0d port0 acks", n0); end
        @(negedge clk);
    endtask

    task automatic test_latency();
        int cyc, nRd, nWr, nOther, stbCyc;
        logic [31:0] sA, sD;
        apply_reset();
        load_word(32'h40, 32'hCAFEF00D);
        do_txn(1'b1, 1'b0, 1'b0, 32'h40, 32'h0, cyc, nRd, nWr, nOther, stbCyc, sA, sD);
        checks++; if (cyc !== 5) begin errors++; $display("FAIL lat3_ack: got %0d expected 5", cyc); end
        checks++; if (nRd !== 1 || stbCyc !== 1) begin errors++; $display("FAIL lat3_strobe: got count=%0d cyc=%0d expected 1 1", nRd, stbCyc); end
        checks++; if (rdataB0 !== 32'hCAFEF00D) begin errors++; $display("FAIL lat3_rdata0: got %h expected cafef00d", rdataB0); end
        checks++; if (rdataB1 !== 32'h0 || nOther !== 0) begin errors++; $display("FAIL lat3_port1: got rdata1=%h acks=%0d expected 0 0", rdataB1, nOther); end
        @(negedge clk);
    endtask

    initial begin
        reset = 1'b1;
        req0 = 1'b0; we0 = 1'b0; addr0 = '0; wdata0 = '0;
        req1 = 1'b0; we1 = 1'b0; addr1 = '0; wdata1 = '0;
        loadEn = 1'b0; loadIdx = '0; loadData = '0;
        test_reset();
        test_single_read();
        test_write_readback();
        test_reset_mid_op();
        test_round_robin();
        test_fixed_priority();
        test_latency();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation still running at %0t", $time);
        $fatal(1, "watchdog expired");
    end

endmodule
`default_nettype wire
